// File: rtl/flow_tick_ctrl.sv
// flow_tick_ctrl: run-time control stage for the flowing-LED shifter.
// Conditions three push-buttons (speed, direction, pause). From them it
// builds the one-clock step strobe, the shift direction, the speed level
// and the run/pause status that the shifter consumes.
module flow_tick_ctrl #(
  parameter int CLK_DIV = 50000,   // clocks per base tick, 2 or more
  parameter int DEB_CNT = 1000000  // stable clocks needed to accept a level change, 1 or more
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_speed,
  input  logic       btn_dir,
  input  logic       btn_pause,
  output logic       step,
  output logic       dir,
  output logic [1:0] speed,
  output logic       running
);

  // Counter widths. Both are guarded so that the smallest legal parameter
  // values still give a counter at least one bit wide.
  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DEB_W = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);

  // Bit positions of the buttons inside the packed button vectors
  localparam int BTN_SPEED = 0;
  localparam int BTN_DIR   = 1;
  localparam int BTN_PAUSE = 2;

  typedef enum logic {
    RUN   = 1'b0,
    PAUSE = 1'b1
  } state_t;

  // Step period minus one, in base ticks: P = 8 >> speed
  function automatic logic [2:0] period_last(input logic [1:0] spd);
    logic [2:0] last;
    case (spd)
      2'd0:    last = 3'd7;
      2'd1:    last = 3'd3;
      2'd2:    last = 3'd1;
      2'd3:    last = 3'd0;
      default: last = 3'd7;
    endcase
    return last;
  endfunction

  logic [2:0]       btn_raw_s;
  logic [2:0]       sync1_r;
  logic [2:0]       sync2_r;
  logic [2:0]       deb_r;
  logic [2:0]       deb_prev_r;
  logic [DEB_W-1:0] deb_cnt_r [3];
  logic [2:0]       press_s;
  logic             speed_ev_s;
  logic             dir_ev_s;
  logic             pause_ev_s;

  state_t           state_r;
  logic             running_r;
  logic             dir_r;
  logic [1:0]       speed_r;
  logic             step_r;
  logic [PRE_W-1:0] presc_r;
  logic [2:0]       step_cnt_r;
  logic             base_tick_s;

  assign btn_raw_s = {btn_pause, btn_dir, btn_speed};

  // Two-flop synchronizer for each asynchronous button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
    end else begin
      sync1_r <= btn_raw_s;
      sync2_r <= sync1_r;
    end
  end

  // Debounce: the counter runs only while the synchronized level disagrees
  // with the accepted level. Once the disagreement has lasted DEB_CNT
  // clocks, the new level is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_r <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        deb_cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2_r[i] != deb_r[i]) begin
          if (deb_cnt_r[i] == DEB_LAST) begin
            deb_r[i]     <= sync2_r[i];
            deb_cnt_r[i] <= '0;
          end else begin
            deb_cnt_r[i] <= deb_cnt_r[i] + DEB_W'(1);
          end
        end else begin
          deb_cnt_r[i] <= '0;
        end
      end
    end
  end

  // Previous debounced level, used to find rising edges (a press)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_prev_r <= 3'b000;
    end else begin
      deb_prev_r <= deb_r;
    end
  end

  // A press event is high for one clock on each rising edge of the
  // debounced level. A button that stays held therefore gives one event.
  always_comb begin
    press_s    = deb_r & ~deb_prev_r;
    speed_ev_s = press_s[BTN_SPEED];
    dir_ev_s   = press_s[BTN_DIR];
    pause_ev_s = press_s[BTN_PAUSE];
  end

  // Run/pause state machine. The running flag is registered with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= RUN;
      running_r <= 1'b1;
    end else begin
      case (state_r)
        RUN: begin
          if (pause_ev_s) begin
            state_r   <= PAUSE;
            running_r <= 1'b0;
          end else begin
            state_r   <= RUN;
            running_r <= 1'b1;
          end
        end
        PAUSE: begin
          if (pause_ev_s) begin
            state_r   <= RUN;
            running_r <= 1'b1;
          end else begin
            state_r   <= PAUSE;
            running_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= RUN;
          running_r <= 1'b1;
        end
      endcase
    end
  end

  // Speed level and direction. Both are accepted in either state, and
  // neither touches the other.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      speed_r <= 2'd0;
      dir_r   <= 1'b0;
    end else begin
      if (speed_ev_s) begin
        speed_r <= speed_r + 2'd1;
      end
      if (dir_ev_s) begin
        dir_r <= ~dir_r;
      end
    end
  end

  assign base_tick_s = (presc_r == PRE_LAST);

  // Prescaler, step counter and the registered step strobe.
  // Any of these events restarts the counters from zero and drops a
  // coincident step:
  //   - entering pause,
  //   - staying in pause,
  //   - leaving pause,
  //   - a speed change.
  // As a result, the first step after a restart arrives exactly P*CLK_DIV
  // clocks later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r    <= '0;
      step_cnt_r <= 3'd0;
      step_r     <= 1'b0;
    end else begin
      if ((state_r != RUN) || pause_ev_s || speed_ev_s) begin
        presc_r    <= '0;
        step_cnt_r <= 3'd0;
        step_r     <= 1'b0;
      end else if (base_tick_s) begin
        presc_r <= '0;
        if (step_cnt_r == period_last(speed_r)) begin
          step_cnt_r <= 3'd0;
          step_r     <= 1'b1;
        end else begin
          step_cnt_r <= step_cnt_r + 3'd1;
          step_r     <= 1'b0;
        end
      end else begin
        presc_r <= presc_r + PRE_W'(1);
        step_r  <= 1'b0;
      end
    end
  end

  assign step    = step_r;
  assign dir     = dir_r;
  assign speed   = speed_r;
  assign running = running_r;

endmodule

// File: doc/flow_tick_ctrl.md
Name: flow_tick_ctrl

Overview:
Control stage directly upstream of the liushuideng flowing-LED shifter. It debounces three board push-buttons (speed, direction, pause) and produces the one-clock step strobe, the shift direction and the run/pause status that the shifter consumes to advance led[7:0]. It replaces a fixed clock divider, so the flow speed, direction and pause can be changed at run time.

Parameters:
CLK_DIV, 50000, clocks per base tick. Legal range is 2 or more.
DEB_CNT, 1000000, consecutive stable clocks needed to accept a button level change. Legal range is 1 or more.

Ports:
clk  input  1  system clock; all logic is on the rising edge
rst  input  1  asynchronous, active-high reset
btn_speed  input  1  raw speed button, active-high, asynchronous to clk
btn_dir  input  1  raw direction button, active-high, asynchronous to clk
btn_pause  input  1  raw pause button, active-high, asynchronous to clk
step  output  1  one-clock pulse; the shifter advances one position per pulse
dir  output  1  shift direction: 0 = toward led[7], 1 = toward led[0]
speed  output  2  current speed level, 0 to 3
running  output  1  1 = RUN, 0 = PAUSE

Behaviour:
- Reset (asynchronous, active-high) forces: step=0, dir=0, speed=0, running=1 (FSM in RUN), and clears all counters, synchronizers and debounced levels to 0. This takes effect immediately, including mid-operation.
- Input conditioning: each button passes through a 2-FF synchronizer.
- Debounce, per button:
  - A counter increments while the synchronized level differs from the debounced level.
  - Any cycle where the two agree clears the counter.
  - When the counter reaches DEB_CNT-1 while they still differ, the debounced level takes the new value and the counter clears.
- Press event: a one-clock pulse on the rising edge of the debounced level. Release produces no event.
- Press latency: about 2 + DEB_CNT clocks from a clean raw edge to the press event. The resulting state change is visible on the next clock edge.
- FSM has two states, RUN and PAUSE:
  - A pause event toggles the state.
  - running = (state == RUN).
- speed:
  - A speed event sets speed to (speed+1) mod 4, so 3 wraps to 0.
  - Step period in base ticks is P = 8 >> speed, giving 8, 4, 2, 1.
- dir: a dir event toggles it. Counters are not affected. Direction changes are accepted in PAUSE as well.
- Speed events are also accepted in PAUSE.
- Prescaler and step counter:
  - The prescaler counts 0 to CLK_DIV-1 and asserts base_tick when it equals CLK_DIV-1, then wraps.
  - The step counter counts base ticks. When step_cnt == P-1 and base_tick is high, step=1 for that cycle and step_cnt clears.
  - In PAUSE, both counters are held at 0 and step=0.
  - On entering RUN, counting restarts from 0. The first step comes P*CLK_DIV clocks later.
  - step is registered.
- Speed-change priority: a speed event clears step_cnt and the prescaler in the same cycle. A step that would have fired in that cycle is suppressed, and the next step comes P_new*CLK_DIV clocks later.
- Simultaneous events:
  - Speed, dir and pause events are applied independently in the same cycle.
  - A pause event entering PAUSE suppresses any coincident step.
  - A pause event leaving PAUSE restarts the counters from 0.
- Step spacing: the step period is exactly P*CLK_DIV clocks. Spacing is exact with no drift, and step is never high on two consecutive cycles unless P*CLK_DIV == 1. That case cannot occur because CLK_DIV is at least 2.
- A button held indefinitely produces exactly one event.

Test Plan:
All scenarios use CLK_DIV=4 and DEB_CNT=3.
1. Release rst, buttons low -> first step pulse 32 clocks after release, then one pulse every 32 clocks; dir=0, speed=0, running=1 throughout.
2. Hold btn_speed high for 10 clocks -> speed=1 and step period 16 clocks. Three further clean presses -> speed goes 2 (8 clks), 3 (4 clks), then wraps to 0 (32 clks).
3. btn_dir pulsed high for 2 clocks (glitch shorter than 2+DEB_CNT) -> no event, dir stays 0. Then a 10-clock press -> dir=1, step period unchanged at 32.
4. Pause press while running -> running=0, zero step pulses over the next 200 clocks; speed press during the pause -> speed=1. Second pause press -> running=1 and first step 16 clocks after the state change.
5. Speed press timed so its event coincides with a due step -> that step is absent and the next step comes exactly 16 clocks later. Pause and dir events in the same cycle -> both applied.
6. Assert rst asynchronously mid-run with speed=2, dir=1, running=0 -> outputs return to step=0, dir=0, speed=0, running=1 before the next clk edge; after release, scenario 1 timing repeats.
